car_direction_detector: RTL and testbench
=========================================

Name: car_direction_detector

Overview:
- Upstream stage of `parking_lot_occupancy`.
- Inputs: the raw outer and inner gate sensors from the board switches (1 = blocked).
- Synchronizes and debounces both sensors, then runs a direction FSM over the filtered pair.
- Outputs: one-cycle `enter` and `exit` pulses that the occupancy counter consumes, plus a `fault` flag for illegal sensor sequences (pedestrian, sensor skip).

Parameters:
- `SYNC_STAGES`, 2: flops in each sensor synchronizer chain; minimum 2.
- `DEBOUNCE_CYCLES`, 3: consecutive cycles a synchronized value must differ from the filtered value before the filtered value updates; minimum 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; derived, never overridden.

Ports:
- `clk` input 1: system clock; the divided board clock, or `CLOCK_50` in simulation.
- `reset` input 1: asynchronous, active-low (0 = reset asserted).
- `outer_raw` input 1: raw outer sensor, asynchronous, 1 = blocked.
- `inner_raw` input 1: raw inner sensor, asynchronous, 1 = blocked.
- `outer_clean` output 1: debounced outer sensor (drives the LED).
- `inner_clean` output 1: debounced inner sensor (drives the LED).
- `enter` output 1: one-cycle pulse, one car completed entry.
- `exit` output 1: one-cycle pulse, one car completed exit.
- `fault` output 1: level, high while the FSM is in `FAULT`.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - All synchronizer flops, debounce counters, `outer_clean`, `inner_clean`, `enter`, `exit` and `fault` go to 0.
  - FSM state goes to `IDLE`.
  - No pulse is emitted on reset entry or release.
- Synchronizer: `SYNC_STAGES` flops per sensor; the output is `s`.
- Debounce, per sensor, independent:
  - If `s` != clean, `cnt` increments. When `cnt` = `DEBOUNCE_CYCLES`-1 and the mismatch persists, clean <= `s` and `cnt` <= 0.
  - If `s` == clean, `cnt` <= 0.
  - A pulse shorter than `DEBOUNCE_CYCLES` cycles never reaches clean.
- Latency: a raw change held stable appears on clean exactly `SYNC_STAGES`+`DEBOUNCE_CYCLES` rising edges after the first edge that samples it. Defaults: 5.
- FSM: registered state, input `ab` = {`outer_clean`, `inner_clean`}. States: `IDLE`, `EN1`, `EN2`, `EN3`, `EX1`, `EX2`, `EX3`, `FAULT`.
  - `IDLE`: 10->`EN1`; 01->`EX1`; 11->`FAULT`; 00 stay.
  - `EN1`: 11->`EN2`; 00->`IDLE` (car backed off, no pulse); 01->`FAULT`; 10 stay.
  - `EN2`: 01->`EN3`; 10->`EN1` (reversal); 00->`FAULT`; 11 stay.
  - `EN3`: 00->`IDLE` and `enter`; 11->`EN2`; 10->`FAULT`; 01 stay.
  - `EX1`/`EX2`/`EX3`: mirror of `EN1`/`EN2`/`EN3` with a and b swapped. `EX3`->`IDLE` on 00 asserts `exit`.
  - `FAULT`: stay until `ab`=00, then `IDLE`; no pulse on that exit.
- `enter` and `exit` are registered outputs:
  - Asserted on the same edge the state moves `EN3`->`IDLE` or `EX3`->`IDLE`.
  - Held high for exactly one cycle.
  - Never both high together.
  - Minimum spacing between two pulses is 4 cycles, since a full pass needs 4 transitions.
- `fault` is registered and equals (state == `FAULT`).
- Simultaneous change of both clean bits in one cycle (e.g. 10->01) counts as an illegal skip and goes to `FAULT`.
- Reset mid-sequence: the partial pass is discarded. After release with sensors still blocked, the FSM sees the new filtered values after the normal latency; 11 at release goes to `FAULT` until both sensors clear.

Decomposition:
- `parking_pkg`:
  - `typedef enum logic [2:0]` `dir_state_t` with the 8 states.
  - Localparams `AB_NONE`=2'b00, `AB_OUTER`=2'b10, `AB_INNER`=2'b01, `AB_BOTH`=2'b11.
- Sub-module `sensor_debounce`: synchronizer plus debounce counter for one sensor, parameters `SYNC_STAGES` and `DEBOUNCE_CYCLES`. It is instantiated twice; the FSM stays in the parent.

Test Plan:
- Reset: hold `reset`=0 with both raw sensors =1 -> all outputs 0, state `IDLE`. Release -> after 5 cycles both clean =1, next edge `fault`=1. Clear both -> `fault`=0 after 6 cycles, no pulse.
- Entry: raw ab sequence 10,11,01,00, each held 8 cycles -> exactly one `enter` pulse of width 1, issued 6 edges after the final 00 is applied. `exit` stays 0, `fault` stays 0.
- Exit: raw ab sequence 01,11,10,00, each held 8 cycles -> exactly one `exit` pulse; `enter` stays 0.
- Glitch and reversal:
  - 2-cycle pulse on `outer_raw` -> `outer_clean` never changes.
  - Sequence 10,11,10,00 -> state returns to `IDLE`, no pulse, no fault.
- Illegal sequences:
  - 10 then 01 directly -> `fault`=1 until 00, then `IDLE`, no pulse.
  - Pedestrian 11 from `IDLE` -> `fault`.
- Reset mid-operation: assert `reset` in `EN3` -> no `enter`. After release, a full entry sequence produces exactly one `enter`.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared types and constants for the parking-lot gate logic.
//                dir_state_t is the direction FSM state; the AB_* constants
//                name the {outer, inner} sensor pair (1 = blocked).
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN1   = 3'd1,
        EN2   = 3'd2,
        EN3   = 3'd3,
        EX1   = 3'd4,
        EX2   = 3'd5,
        EX3   = 3'd6,
        FAULT = 3'd7
    } dir_state_t;

    localparam logic [1:0] AB_NONE  = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_INNER = 2'b01;
    localparam logic [1:0] AB_BOTH  = 2'b11;

endpackage : parking_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_debounce
//  Description : Synchronizer chain plus debounce filter for one gate sensor.
//                The filtered output only follows the synchronized input
//                after it has disagreed for DEBOUNCE_CYCLES consecutive
//                cycles, so shorter glitches are swallowed.
//  Ports       : clk     - system clock
//                reset   - asynchronous, active-low
//                i_raw   - raw asynchronous sensor (1 = blocked)
//                o_clean - debounced, registered sensor value
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int SYNC_STAGES     = 2,   // minimum 2
    parameter int DEBOUNCE_CYCLES = 3    // minimum 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   w_sync;

    // Oldest flop of the chain is the metastability-safe sample.
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync != r_clean) begin
                // The cycle that sees the count at its last value is the
                // DEBOUNCE_CYCLES-th consecutive mismatch: accept it.
                if (r_cnt == C_CNT_LAST) begin
                    r_clean <= w_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_clean = r_clean;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/car_direction_detector.sv
`default_nettype none
// ============================================================================
//  Module      : car_direction_detector
//  Description : Debounces the outer and inner gate sensors and tracks a car
//                through the gate. A full outer->both->inner->none pass
//                yields one enter pulse, the mirror pass one exit pulse.
//                Illegal sequences park the FSM in FAULT until both clear.
//  Ports       : clk         - system clock
//                reset       - asynchronous, active-low
//                outer_raw   - raw outer sensor (1 = blocked)
//                inner_raw   - raw inner sensor (1 = blocked)
//                outer_clean - debounced outer sensor
//                inner_clean - debounced inner sensor
//                enter       - one-cycle pulse per completed entry
//                exit        - one-cycle pulse per completed exit
//                fault       - high while the FSM sits in FAULT
//  Revision    : 1.0 - initial release
// ============================================================================
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic outer_raw,
    input  logic inner_raw,
    output logic outer_clean,
    output logic inner_clean,
    output logic enter,
    output logic exit,
    output logic fault
);

    dir_state_t r_state;
    dir_state_t w_next;
    logic       w_enter;
    logic       w_exit;
    logic       r_enter;
    logic       r_exit;
    logic       r_fault;
    logic [1:0] w_ab;

    sensor_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_outer (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (outer_raw),
        .o_clean (outer_clean)
    );

    sensor_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_inner (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (inner_raw),
        .o_clean (inner_clean)
    );

    assign w_ab = {outer_clean, inner_clean};

    // Each legal step changes exactly one sensor bit; any other change
    // (including both bits flipping together) falls through to FAULT.
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        case (r_state)
            IDLE: begin
                case (w_ab)
                    AB_OUTER: w_next = EN1;
                    AB_INNER: w_next = EX1;
                    AB_BOTH:  w_next = FAULT;
                    default:  w_next = IDLE;
                endcase
            end
            EN1: begin
                case (w_ab)
                    AB_BOTH:  w_next = EN2;
                    AB_NONE:  w_next = IDLE;     // car backed off
                    AB_INNER: w_next = FAULT;
                    default:  w_next = EN1;
                endcase
            end
            EN2: begin
                case (w_ab)
                    AB_INNER: w_next = EN3;
                    AB_OUTER: w_next = EN1;      // reversal
                    AB_NONE:  w_next = FAULT;
                    default:  w_next = EN2;
                endcase
            end
            EN3: begin
                case (w_ab)
                    AB_NONE: begin
                        w_next  = IDLE;
                        w_enter = 1'b1;
                    end
                    AB_BOTH:  w_next = EN2;
                    AB_OUTER: w_next = FAULT;
                    default:  w_next = EN3;
                endcase
            end
            EX1: begin
                case (w_ab)
                    AB_BOTH:  w_next = EX2;
                    AB_NONE:  w_next = IDLE;
                    AB_OUTER: w_next = FAULT;
                    default:  w_next = EX1;
                endcase
            end
            EX2: begin
                case (w_ab)
                    AB_OUTER: w_next = EX3;
                    AB_INNER: w_next = EX1;
                    AB_NONE:  w_next = FAULT;
                    default:  w_next = EX2;
                endcase
            end
            EX3: begin
                case (w_ab)
                    AB_NONE: begin
                        w_next = IDLE;
                        w_exit = 1'b1;
                    end
                    AB_BOTH:  w_next = EX2;
                    AB_INNER: w_next = FAULT;
                    default:  w_next = EX3;
                endcase
            end
            FAULT: begin
                if (w_ab == AB_NONE) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so that fault tracks the
    // state register and the pulses coincide with the move back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_enter <= w_enter;
            r_exit  <= w_exit;
            r_fault <= (w_next == FAULT);
        end
    end

    assign enter = r_enter;
    assign exit  = r_exit;
    assign fault = r_fault;

endmodule : car_direction_detector
`default_nettype wire

// File: tb/tb_car_direction_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_direction_detector
//  Description : Directed self-checking bench for car_direction_detector
//                with default parameters (5-edge sensor latency, FSM output
//                one edge later).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_car_direction_detector;

    logic clk;
    logic rst_n;
    logic outer_raw;
    logic inner_raw;
    logic outer_clean;
    logic inner_clean;
    logic enter;
    logic exit;
    logic fault;

    int n_checks;
    int n_fail;

    // Activity observed on the falling edge, away from the active edge.
    int enter_cnt;
    int exit_cnt;
    int fault_cyc;
    int outer_rise;
    int width_err;
    int both_err;
    logic prev_enter;
    logic prev_exit;
    logic prev_outer;

    int base_en;
    int base_ex;
    int base_fc;
    int base_or;

    car_direction_detector dut (
        .clk         (clk),
        .reset       (rst_n),
        .outer_raw   (outer_raw),
        .inner_raw   (inner_raw),
        .outer_clean (outer_clean),
        .inner_clean (inner_clean),
        .enter       (enter),
        .exit        (exit),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        enter_cnt  = 0;
        exit_cnt   = 0;
        fault_cyc  = 0;
        outer_rise = 0;
        width_err  = 0;
        both_err   = 0;
        prev_enter = 1'b0;
        prev_exit  = 1'b0;
        prev_outer = 1'b0;
    end

    always @(negedge clk) begin
        if (enter) enter_cnt <= enter_cnt + 1;
        if (exit)  exit_cnt  <= exit_cnt + 1;
        if (fault) fault_cyc <= fault_cyc + 1;
        if (outer_clean && !prev_outer) outer_rise <= outer_rise + 1;
        if ((enter && prev_enter) || (exit && prev_exit)) width_err <= width_err + 1;
        if (enter && exit) both_err <= both_err + 1;
        prev_enter <= enter;
        prev_exit  <= exit;
        prev_outer <= outer_clean;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ab);
        {outer_raw, inner_raw} = ab;
    endtask

    // Advance n rising edges and park 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        base_en = enter_cnt;
        base_ex = exit_cnt;
        base_fc = fault_cyc;
        base_or = outer_rise;
    endtask

    task automatic seq(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        drive(a); step(8);
        drive(b); step(8);
        drive(c); step(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(2'b11);
        step(3);

        // ---- reset held with both sensors blocked ----
        check("rst_outer_clean", outer_clean, 0);
        check("rst_inner_clean", inner_clean, 0);
        check("rst_enter", enter, 0);
        check("rst_exit", exit, 0);
        check("rst_fault", fault, 0);

        rst_n = 1'b1;
        step(4);
        check("rel_clean_e4", {outer_clean, inner_clean}, 0);
        step(1);
        check("rel_clean_e5", {outer_clean, inner_clean}, 3);
        check("rel_fault_e5", fault, 0);
        step(1);
        check("rel_fault_e6", fault, 1);
        snap();
        drive(2'b00);
        step(5);
        check("clr_fault_e5", fault, 1);
        step(1);
        check("clr_fault_e6", fault, 0);
        step(4);
        check("clr_no_enter", enter_cnt - base_en, 0);
        check("clr_no_exit", exit_cnt - base_ex, 0);

        // ---- full entry ----
        snap();
        drive(2'b10);
        step(4);
        check("ent_lat_e4", outer_clean, 0);
        step(1);
        check("ent_lat_e5", outer_clean, 1);
        step(3);
        drive(2'b11); step(8);
        drive(2'b01); step(8);
        drive(2'b00);
        step(5);
        check("ent_pulse_e5", enter, 0);
        step(1);
        check("ent_pulse_e6", enter, 1);
        check("ent_exit_low", exit, 0);
        step(1);
        check("ent_pulse_e7", enter, 0);
        step(4);
        check("ent_count", enter_cnt - base_en, 1);
        check("ent_exit_count", exit_cnt - base_ex, 0);
        check("ent_fault_cyc", fault_cyc - base_fc, 0);

        // ---- full exit ----
        snap();
        seq(2'b01, 2'b11, 2'b10);
        drive(2'b00);
        step(5);
        check("ex_pulse_e5", exit, 0);
        step(1);
        check("ex_pulse_e6", exit, 1);
        check("ex_enter_low", enter, 0);
        step(1);
        check("ex_pulse_e7", exit, 0);
        step(4);
        check("ex_count", exit_cnt - base_ex, 1);
        check("ex_enter_count", enter_cnt - base_en, 0);
        check("ex_fault_cyc", fault_cyc - base_fc, 0);

        // ---- two-cycle glitch on outer ----
        snap();
        drive(2'b10); step(2);
        drive(2'b00); step(10);
        check("glitch_outer_rise", outer_rise - base_or, 0);
        check("glitch_outer_clean", outer_clean, 0);

        // ---- reversal back out of the gate ----
        snap();
        seq(2'b10, 2'b11, 2'b10);
        drive(2'b00); step(10);
        check("rev_enter", enter_cnt - base_en, 0);
        check("rev_exit", exit_cnt - base_ex, 0);
        check("rev_fault", fault_cyc - base_fc, 0);

        // ---- skip 10 -> 01 ----
        snap();
        drive(2'b10); step(8);
        drive(2'b01);
        step(5);
        check("skip_fault_e5", fault, 0);
        step(1);
        check("skip_fault_e6", fault, 1);
        step(6);
        check("skip_fault_hold", fault, 1);
        drive(2'b00);
        step(5);
        check("skip_clr_e5", fault, 1);
        step(1);
        check("skip_clr_e6", fault, 0);
        step(4);
        check("skip_no_pulse", (enter_cnt - base_en) + (exit_cnt - base_ex), 0);

        // ---- pedestrian: both sensors at once from IDLE ----
        snap();
        drive(2'b11);
        step(5);
        check("ped_fault_e5", fault, 0);
        step(1);
        check("ped_fault_e6", fault, 1);
        drive(2'b00); step(10);
        check("ped_cleared", fault, 0);
        check("ped_no_pulse", (enter_cnt - base_en) + (exit_cnt - base_ex), 0);

        // ---- reset while in EN3 ----
        snap();
        seq(2'b10, 2'b11, 2'b01);
        check("mid_inner_before", inner_clean, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_inner", inner_clean, 0);
        check("mid_rst_enter", enter, 0);
        drive(2'b00);
        step(3);
        rst_n = 1'b1;
        step(12);
        check("mid_no_enter", enter_cnt - base_en, 0);
        check("mid_no_fault", fault_cyc - base_fc, 0);
        seq(2'b10, 2'b11, 2'b01);
        drive(2'b00); step(10);
        check("mid_reentry_count", enter_cnt - base_en, 1);
        check("mid_reentry_exit", exit_cnt - base_ex, 0);

        // ---- global pulse-shape properties ----
        check("pulse_width_one", width_err, 0);
        check("pulse_never_both", both_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule : tb_car_direction_detector
`default_nettype wire
